// File: rtl/mul_seq_unit_if.sv
// Handshake and data bundle between the control unit and the sequential multiplier.
// The control unit drives the request side; the multiplier returns product/busy/done.
interface mul_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               mul_signed;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, mul_signed, A, B,
    input  product, busy, done
  );

  modport slave (
    input  start, mul_signed, A, B,
    output product, busy, done
  );
endinterface

// File: rtl/mul_seq_unit.sv
// Radix-2 shift-add multiplier: WIDTH iterations on magnitudes, then one sign-fix cycle.
// Product is registered and only changes on completion or reset.
module mul_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_unit_if.slave mul
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic [PW-1:0]    product;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    full;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? ((~x) + WIDTH'(1)) : x;
  endfunction

  // acc is the upper half of the running product; mplier shifts out into the lower half
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    full = {acc, mplier};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (mul.start) begin
            mcand  <= mag(mul.A, mul.mul_signed);
            mplier <= mag(mul.B, mul.mul_signed);
            neg    <= mul.mul_signed & (mul.A[WIDTH-1] ^ mul.B[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          {acc, mplier} <= {sum, mplier[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          product <= neg ? ((~full) + PW'(1)) : full;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul.product = product;
  assign mul.busy    = busy;
  assign mul.done    = done;
endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: cycle-exact latency, sign handling, ignored/held start, async reset.
module tb_mul_seq_unit;
  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;
  logic [63:0] exp_prod;

  mul_seq_unit_if #(.WIDTH(32)) bus ();

  mul_seq_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Busy window E0..E32 with product held, completion at E33, done low at E34
  task automatic run_mul(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    bus.start      = 1'b1;
    bus.mul_signed = sgn;
    bus.A          = a;
    bus.B          = b;
    tick();
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0BAD_F00D;
    check({tag, " accept busy/done"}, {62'd0, bus.busy, bus.done}, 64'd2);
    for (int i = 1; i <= 32; i++) begin
      tick();
      check({tag, " busy/done"}, {62'd0, bus.busy, bus.done}, 64'd2);
      check({tag, " product held"}, bus.product, exp_prod);
    end
    tick();
    exp_prod = exp;
    check({tag, " done busy/done"}, {62'd0, bus.busy, bus.done}, 64'd1);
    check({tag, " product"}, bus.product, exp_prod);
    tick();
    check({tag, " after busy/done"}, {62'd0, bus.busy, bus.done}, 64'd0);
    check({tag, " product kept"}, bus.product, exp_prod);
  endtask

  initial begin
    n_asserts      = 0;
    n_fail         = 0;
    exp_prod       = 64'd0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mul_signed = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    #12;
    check("reset product", bus.product, 64'd0);
    check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    rst_n = 1'b1;

    run_mul("u 3x5",       1'b0, 32'd3,         32'd5,         64'h0000_0000_0000_000F);
    run_mul("u max",       1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_mul("s -1x-1",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_mul("s -7x3",      1'b1, 32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB);
    run_mul("s min*min",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mul("s min*max",   1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    run_mul("u 8000x2",    1'b0, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000);
    run_mul("u 0x",        1'b0, 32'd0,         32'h1234_5678, 64'd0);
    run_mul("s 3x-5",      1'b1, 32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    run_mul("s 0x",        1'b1, 32'd0,         32'h1234_5678, 64'd0);
    run_mul("s 0x-5",      1'b1, 32'd0,         32'hFFFF_FFFB, 64'd0);

    // start pulsed again at cycle 10 with new operands must be ignored
    bus.start = 1'b1; bus.mul_signed = 1'b0; bus.A = 32'd6; bus.B = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    bus.start = 1'b1; bus.A = 32'd9; bus.B = 32'd9;
    tick();
    bus.start = 1'b0;
    check("ignored busy", {63'd0, bus.busy}, 64'd1);
    for (int i = 11; i <= 32; i++) tick();
    check("ignored pre-done busy/done", {62'd0, bus.busy, bus.done}, 64'd2);
    tick();
    exp_prod = 64'd42;
    check("ignored done", {62'd0, bus.busy, bus.done}, 64'd1);
    check("ignored product", bus.product, exp_prod);
    tick();
    check("ignored idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // start held high: second accept on the edge after done, second done at E67
    bus.start = 1'b1; bus.A = 32'd6; bus.B = 32'd7;
    tick();
    check("held accept", {62'd0, bus.busy, bus.done}, 64'd2);
    for (int i = 1; i <= 32; i++) tick();
    tick();
    check("held done1", {62'd0, bus.busy, bus.done}, 64'd1);
    check("held product1", bus.product, 64'd42);
    tick();
    check("held reaccept", {62'd0, bus.busy, bus.done}, 64'd2);
    for (int i = 35; i <= 66; i++) tick();
    check("held pre-done2", {62'd0, bus.busy, bus.done}, 64'd2);
    tick();
    check("held done2", {62'd0, bus.busy, bus.done}, 64'd1);
    check("held product2", bus.product, 64'd42);
    bus.start = 1'b0;
    tick();
    check("held idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // asynchronous reset mid-operation
    bus.start = 1'b1; bus.A = 32'd6; bus.B = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    check("pre-reset busy", {63'd0, bus.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_prod = 64'd0;
    check("async reset product", bus.product, 64'd0);
    check("async reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    check("reset held busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    run_mul("post-reset 2x2", 1'b0, 32'd2, 32'd2, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
